hmac_block_seq: RTL and testbench
=================================

Name: hmac_block_seq

Overview:
- Parametrised HMAC pad/block sequencer that feeds a word-serial hash core with a two-block HMAC pass.
- Block 0 is (key XOR pad byte). Block 1 is a supplied digest plus standard MD padding and a 64-bit length field.
- Adds over the previous pad generator: selectable ipad/opad mode, valid/ready backpressure, block framing flags, generic digest/key/word widths.
- Sits between the HMAC controller and the SHA compression core.

Parameters:
- WORD_W, 32: output word width; multiple of 8.
- BLOCK_W, 512: hash block width. Key width equals BLOCK_W. WORDS = BLOCK_W/WORD_W.
- DIGEST_W, 160: digest width. Must be a multiple of WORD_W, with DIGEST_W/WORD_W <= WORDS-3.
- LEN_W, 64: length-field width at the tail of block 1; multiple of WORD_W.

Ports:
- clk, input, 1: single clock; all logic on rising edge.
- rst, input, 1: synchronous, active-high reset.
- start, input, 1: begin sequence; sampled only in IDLE.
- mode, input, 1: 0 = inner pad byte 0x36, 1 = outer pad byte 0x5C; captured at start.
- key, input, BLOCK_W: HMAC key, zero-padded by the caller; captured at start.
- digest_in, input, DIGEST_W: digest/message for block 1; captured at start.
- word_out, output, WORD_W: current word, most-significant word first.
- word_valid, output, 1: word_out is valid.
- word_ready, input, 1: core accepts the word. A transfer occurs when word_valid && word_ready.
- blk_first, output, 1: high with word 0 of each block.
- blk_last, output, 1: high with word WORDS-1 of each block.
- seq_last, output, 1: high with the final word of block 1.
- busy, output, 1: high from the cycle after start until done.
- done, output, 1: one-cycle pulse after the final transfer.

Behaviour:
- Reset values: word_out 0, all flags 0, state IDLE, word counter 0, captured registers 0.
- Reset is honoured in any state. It aborts a sequence immediately with no done pulse.
- States: IDLE -> KEY_BLK -> MSG_BLK -> FIN -> IDLE.
- IDLE: on start=1, capture key, digest_in, mode, go to KEY_BLK. Latency: word 0 is valid in the cycle after start.
- KEY_BLK: word i = key[BLOCK_W-1-i*WORD_W -: WORD_W] XOR the pad byte replicated WORD_W/8 times. After the transfer of word WORDS-1, go to MSG_BLK with the counter at 0.
- MSG_BLK words, with D = DIGEST_W/WORD_W:
  - i < D: digest words, MSB first.
  - i == D: 0x80 in the top byte, zeros below.
  - D < i < WORDS-LEN_W/WORD_W: zero.
  - Tail LEN_W bits: BLOCK_W+DIGEST_W, big-endian (672 = 0x2A0 for the defaults).
  - After the transfer of word WORDS-1, go to FIN.
- FIN: done=1 for one cycle, busy=0, return to IDLE.
  - A start sampled in the FIN cycle is ignored; a new start is accepted from IDLE only.
- Counter advances only on a transfer. It wraps WORDS-1 -> 0 at each block boundary.
- Backpressure: while word_valid && !word_ready, word_out and all flags hold unchanged. Stall length is unbounded.
- word_valid stays high continuously in KEY_BLK/MSG_BLK; there is no bubble at the block boundary (default build).
- start during busy is ignored, and captured values are not disturbed.
- Input changes on key/digest_in/mode after capture have no effect.
- blk_first and blk_last are coincident only if WORDS == 1, which is illegal by parameter rule.

Optional Feature:
- Macro: HMAC_BLOCK_SEQ_GAP_EN.
- Defined: adds parameter BLK_GAP (default 80) and a GAP state entered after the block-0 final transfer.
  - word_valid=0 for exactly BLK_GAP cycles, then MSG_BLK starts.
  - This gives the core compression time when it lacks a ready stall.
  - busy stays high during GAP.
- Undefined: no GAP state; blocks are back-to-back as described above.

Test Plan:
- Zero key, mode=1, word_ready=1, start pulse → 16 words 0x5C5C5C5C, then block 1. done arrives 34 cycles after start (default build).
- digest_in=0x0123456789ABCDEF0011223344556677DEADBEEF, mode=0 → block-1 words 0x01234567 … 0xDEADBEEF, then 0x80000000, 8 zero words, 0x00000000, 0x000002A0. seq_last and blk_last are high on the last word.
- Key word 0 = 0xFFFFFFFF, mode=0 → first word 0xC9C9C9C9 with blk_first=1.
- word_ready held low 5 cycles at key word 7 → word_out/flags stable for 5 cycles, no word skipped or duplicated, total length +5 cycles.
- start re-asserted mid-KEY_BLK with a different key → ignored; output matches the original key.
- rst asserted during MSG_BLK word 3 → next cycle all outputs 0, no done. A fresh start replays from key word 0.
- With HMAC_BLOCK_SEQ_GAP_EN and BLK_GAP=80 → word_valid low exactly 80 cycles between block-0 blk_last and block-1 blk_first.

Source files
------------

// File: rtl/hmac_block_seq.sv
// rtl/hmac_block_seq.sv - HMAC pad/block sequencer feeding a word-serial hash core
//
// Purpose:
//   Produces a two-block HMAC pass, one word at a time, most-significant word first.
//   Block 0 is (key XOR pad byte), where the pad byte is 0x36 (mode=0) or 0x5C (mode=1).
//   Block 1 holds the supplied digest, then the 0x80 marker, then zero fill. The last
//   LEN_W bits of block 1 carry the big-endian bit length BLOCK_W+DIGEST_W.
//   key, digest_in and mode are captured when start is accepted in IDLE.
//
// Optional build macro:
//   HMAC_BLOCK_SEQ_GAP_EN - adds parameter BLK_GAP and a GAP state between the blocks.
//   In that state word_valid is low for exactly BLK_GAP cycles.
//
// Ports:
//   clk        - clock; all logic uses the rising edge
//   rst        - synchronous, active-high reset
//   start      - begin a sequence (sampled in IDLE only)
//   mode       - 0 = inner pad 0x36, 1 = outer pad 0x5C
//   key        - BLOCK_W-bit HMAC key, zero-padded by the caller
//   digest_in  - DIGEST_W-bit digest/message placed at the head of block 1
//   word_out   - current output word
//   word_valid - word_out is valid
//   word_ready - core accepts the word; a transfer is word_valid && word_ready
//   blk_first  - with word 0 of each block
//   blk_last   - with word WORDS-1 of each block
//   seq_last   - with the final word of block 1
//   busy       - a sequence is in progress
//   done       - one-cycle pulse after the final transfer

module hmac_block_seq #(
  parameter int WORD_W   = 32,
  parameter int BLOCK_W  = 512,
  parameter int DIGEST_W = 160,
  parameter int LEN_W    = 64
`ifdef HMAC_BLOCK_SEQ_GAP_EN
  ,
  parameter int BLK_GAP  = 80
`endif
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                mode,
  input  logic [BLOCK_W-1:0]  key,
  input  logic [DIGEST_W-1:0] digest_in,
  output logic [WORD_W-1:0]   word_out,
  output logic                word_valid,
  input  logic                word_ready,
  output logic                blk_first,
  output logic                blk_last,
  output logic                seq_last,
  output logic                busy,
  output logic                done
);

  localparam int WORDS = BLOCK_W / WORD_W;
  localparam int CNT_W = (WORDS > 1) ? $clog2(WORDS) : 1;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WORDS - 1);
  localparam logic [LEN_W-1:0] LEN_VAL  = LEN_W'(BLOCK_W + DIGEST_W);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_KEY  = 3'd1;
  localparam logic [2:0] S_MSG  = 3'd2;
  localparam logic [2:0] S_FIN  = 3'd3;
`ifdef HMAC_BLOCK_SEQ_GAP_EN
  localparam logic [2:0] S_GAP  = 3'd4;
  localparam int GAP_W = (BLK_GAP > 1) ? $clog2(BLK_GAP) : 1;
`endif

  logic [2:0]          state;
  logic [CNT_W-1:0]    cnt;
  logic [BLOCK_W-1:0]  key_r;
  logic [DIGEST_W-1:0] digest_r;
  logic                mode_r;
`ifdef HMAC_BLOCK_SEQ_GAP_EN
  logic [GAP_W-1:0]    gap_cnt;
`endif

  logic                xfer;
  logic                cnt_last;
  logic [7:0]          pad_byte;
  logic [WORD_W-1:0]   pad_word;
  logic [BLOCK_W-1:0]  key_sh;
  logic [BLOCK_W-1:0]  msg_blk;
  logic [BLOCK_W-1:0]  msg_sh;

  assign xfer     = word_valid && word_ready;
  assign cnt_last = (cnt == CNT_LAST);

  // --------------------------------------------------------------------------
  // Sequencing
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      cnt      <= '0;
      key_r    <= '0;
      digest_r <= '0;
      mode_r   <= 1'b0;
`ifdef HMAC_BLOCK_SEQ_GAP_EN
      gap_cnt  <= '0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            key_r    <= key;
            digest_r <= digest_in;
            mode_r   <= mode;
            cnt      <= '0;
            state    <= S_KEY;
          end
        end
        S_KEY: begin
          if (xfer) begin
            if (cnt_last) begin
              cnt <= '0;
`ifdef HMAC_BLOCK_SEQ_GAP_EN
              // A zero-length gap degenerates to back-to-back blocks.
              state   <= (BLK_GAP > 0) ? S_GAP : S_MSG;
              gap_cnt <= '0;
`else
              state <= S_MSG;
`endif
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end
`ifdef HMAC_BLOCK_SEQ_GAP_EN
        S_GAP: begin
          if (gap_cnt == GAP_W'(BLK_GAP - 1)) begin
            gap_cnt <= '0;
            state   <= S_MSG;
          end else begin
            gap_cnt <= gap_cnt + 1'b1;
          end
        end
`endif
        S_MSG: begin
          if (xfer) begin
            if (cnt_last) begin
              cnt   <= '0;
              state <= S_FIN;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end
        S_FIN: begin
          // Start is deliberately not looked at here; a new pass begins from IDLE.
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Word generation
  // --------------------------------------------------------------------------
  // All outputs derive from registered state only, so they hold steady while
  // the core stalls with word_ready low.
  assign pad_byte = mode_r ? 8'h5C : 8'h36;
  assign pad_word = {(WORD_W/8){pad_byte}};

  // Block 1 image: digest at the top, the 0x80 marker right below it, and the
  // length field in the bottom LEN_W bits. Everything in between is zero.
  assign msg_blk = (BLOCK_W'(digest_r) << (BLOCK_W - DIGEST_W))
                 | (BLOCK_W'(8'h80)    << (BLOCK_W - DIGEST_W - 8))
                 |  BLOCK_W'(LEN_VAL);

  // Bring the selected word to the top of the vector, then take the top slice.
  assign key_sh = key_r   << (int'(cnt) * WORD_W);
  assign msg_sh = msg_blk << (int'(cnt) * WORD_W);

  always_comb begin
    word_out   = '0;
    word_valid = 1'b0;
    case (state)
      S_KEY: begin
        word_out   = key_sh[BLOCK_W-1 -: WORD_W] ^ pad_word;
        word_valid = 1'b1;
      end
      S_MSG: begin
        word_out   = msg_sh[BLOCK_W-1 -: WORD_W];
        word_valid = 1'b1;
      end
      default: begin
        word_out   = '0;
        word_valid = 1'b0;
      end
    endcase
  end

  assign blk_first = word_valid && (cnt == '0);
  assign blk_last  = word_valid && cnt_last;
  assign seq_last  = (state == S_MSG) && cnt_last;
  assign done      = (state == S_FIN);
`ifdef HMAC_BLOCK_SEQ_GAP_EN
  assign busy      = (state == S_KEY) || (state == S_MSG) || (state == S_GAP);
`else
  assign busy      = (state == S_KEY) || (state == S_MSG);
`endif

endmodule

// File: tb/tb_hmac_block_seq.sv
// tb/tb_hmac_block_seq.sv - self-checking bench for hmac_block_seq (default build)

module tb_hmac_block_seq;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic         mode;
  logic [511:0] key;
  logic [159:0] digest_in;
  logic [31:0]  word_out;
  logic         word_valid;
  logic         word_ready;
  logic         blk_first;
  logic         blk_last;
  logic         seq_last;
  logic         busy;
  logic         done;

  int total = 0;
  int bad   = 0;

  logic [31:0] exp_w[32];
  logic [31:0] obs_w[$];
  logic        obs_f[$];
  logic        obs_l[$];
  logic        obs_s[$];
  int          run_cycles;
  int          run_stalls;

  typedef struct {
    logic [511:0] key;
    logic [159:0] dig;
    logic         mode;
    int           stall_at;
    int           stall_len;
    bit           mid_start;
    logic [31:0]  w0;
    logic [31:0]  m0;
    logic [31:0]  m4;
    logic [31:0]  m5;
    logic [31:0]  m15;
    int           cycles;
  } vec_t;

  vec_t vecs[5];

  hmac_block_seq #(
    .WORD_W(32), .BLOCK_W(512), .DIGEST_W(160), .LEN_W(64)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .mode(mode), .key(key),
    .digest_in(digest_in), .word_out(word_out), .word_valid(word_valid),
    .word_ready(word_ready), .blk_first(blk_first), .blk_last(blk_last),
    .seq_last(seq_last), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  function automatic logic [511:0] rand_key();
    logic [511:0] r;
    for (int i = 0; i < 16; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  function automatic logic [159:0] rand_dig();
    logic [159:0] r;
    for (int i = 0; i < 5; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  // Reference: the two HMAC blocks as byte arrays, then packed big-endian into words.
  task automatic build_model(input logic [511:0] k, input logic [159:0] d, input logic m);
    logic [7:0]  b0[64];
    logic [7:0]  b1[64];
    logic [63:0] len;
    len = 64'(512 + 160);
    for (int i = 0; i < 64; i++) begin
      b0[i] = k[511 - 8*i -: 8] ^ (m ? 8'h5C : 8'h36);
      if (i < 20)       b1[i] = d[159 - 8*i -: 8];
      else if (i == 20) b1[i] = 8'h80;
      else if (i >= 56) b1[i] = len[63 - 8*(i-56) -: 8];
      else              b1[i] = 8'h00;
    end
    for (int w = 0; w < 16; w++) begin
      exp_w[w]      = {b0[4*w], b0[4*w+1], b0[4*w+2], b0[4*w+3]};
      exp_w[w + 16] = {b1[4*w], b1[4*w+1], b1[4*w+2], b1[4*w+3]};
    end
  endtask

  // Runs one full sequence from a negedge; records every transfer.
  task automatic run_seq(input logic [511:0] k, input logic [159:0] d, input logic m,
                         input int stall_at, input int stall_len,
                         input bit rand_rdy, input bit mid_start);
    int          cyc;
    int          st;
    bit          pstall;
    bit          fin;
    logic [31:0] pw;
    logic        pf, pl, ps;
    obs_w.delete(); obs_f.delete(); obs_l.delete(); obs_s.delete();
    run_stalls = 0; st = 0; pstall = 0; fin = 0; run_cycles = -1;
    pw = '0; pf = 0; pl = 0; ps = 0;
    key = k; digest_in = d; mode = m; start = 1'b1; word_ready = 1'b1;
    cyc = 1;
    @(posedge clk);
    while (!fin) begin
      @(negedge clk);
      cyc++;
      start     = mid_start && (cyc == 6);
      key       = mid_start ? '1 : rand_key();
      digest_in = rand_dig();
      mode      = 1'($urandom);
      if (pstall) begin
        chk("stall_word", {32'h0, word_out}, {32'h0, pw});
        chk("stall_flags", {60'h0, word_valid, blk_first, blk_last, seq_last},
            {60'h0, 1'b1, pf, pl, ps});
      end
      if (done) begin
        fin = 1;
        run_cycles = cyc;
      end else if (cyc > 400) begin
        chk("timeout", 64'd1, 64'd0);
        fin = 1;
      end else begin
        chk("busy_run", {63'h0, busy}, 64'd1);
        chk("valid_run", {63'h0, word_valid}, 64'd1);
        if (stall_at >= 0 && obs_w.size() == stall_at && st < stall_len) begin
          word_ready = 1'b0;
          st++;
        end else begin
          word_ready = rand_rdy ? ($urandom_range(0, 3) != 0) : 1'b1;
        end
        if (word_valid && word_ready) begin
          obs_w.push_back(word_out);
          obs_f.push_back(blk_first);
          obs_l.push_back(blk_last);
          obs_s.push_back(seq_last);
        end
        pstall = word_valid && !word_ready;
        if (pstall) run_stalls++;
        pw = word_out; pf = blk_first; pl = blk_last; ps = seq_last;
      end
    end
    // Start during the done cycle must be ignored.
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("done_pulse", {63'h0, done}, 64'd0);
    chk("busy_after", {63'h0, busy}, 64'd0);
    chk("valid_after_fin_start", {63'h0, word_valid}, 64'd0);
    @(negedge clk);
    chk("idle_after_fin_start", {63'h0, word_valid}, 64'd0);
  endtask

  task automatic check_stream();
    chk("n_words", obs_w.size(), 64'd32);
    for (int i = 0; i < obs_w.size() && i < 32; i++) begin
      chk($sformatf("word%0d", i), {32'h0, obs_w[i]}, {32'h0, exp_w[i]});
      chk($sformatf("first%0d", i), {63'h0, obs_f[i]}, {63'h0, (i % 16) == 0});
      chk($sformatf("last%0d", i), {63'h0, obs_l[i]}, {63'h0, (i % 16) == 15});
      chk($sformatf("seq%0d", i), {63'h0, obs_s[i]}, {63'h0, i == 31});
    end
    // Cycles counted from the start cycle to the done cycle, both inclusive.
    chk("done_latency", 64'(run_cycles), 64'(34 + run_stalls));
  endtask

  initial begin
    logic [511:0] rk;
    logic [159:0] rd;
    logic         rm;

    vecs[0] = '{key: '0, dig: '0, mode: 1'b1, stall_at: -1, stall_len: 0, mid_start: 0,
                w0: 32'h5C5C5C5C, m0: 32'h0, m4: 32'h0, m5: 32'h80000000,
                m15: 32'h000002A0, cycles: 34};
    vecs[1] = '{key: '0, dig: 160'h0123456789ABCDEF0011223344556677DEADBEEF, mode: 1'b0,
                stall_at: -1, stall_len: 0, mid_start: 0,
                w0: 32'h36363636, m0: 32'h01234567, m4: 32'hDEADBEEF, m5: 32'h80000000,
                m15: 32'h000002A0, cycles: 34};
    vecs[2] = '{key: {32'hFFFFFFFF, 480'h0}, dig: '0, mode: 1'b0, stall_at: -1,
                stall_len: 0, mid_start: 0,
                w0: 32'hC9C9C9C9, m0: 32'h0, m4: 32'h0, m5: 32'h80000000,
                m15: 32'h000002A0, cycles: 34};
    vecs[3] = '{key: '0, dig: '0, mode: 1'b1, stall_at: 7, stall_len: 5, mid_start: 0,
                w0: 32'h5C5C5C5C, m0: 32'h0, m4: 32'h0, m5: 32'h80000000,
                m15: 32'h000002A0, cycles: 39};
    vecs[4] = '{key: '0, dig: 160'h1, mode: 1'b0, stall_at: -1, stall_len: 0, mid_start: 1,
                w0: 32'h36363636, m0: 32'h0, m4: 32'h00000001, m5: 32'h80000000,
                m15: 32'h000002A0, cycles: 34};

    rst = 1'b1; start = 1'b0; mode = 1'b0; key = '0; digest_in = '0; word_ready = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_word", {32'h0, word_out}, 64'd0);
    chk("rst_flags", {58'h0, word_valid, blk_first, blk_last, seq_last, busy, done}, 64'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("idle_flags", {58'h0, word_valid, blk_first, blk_last, seq_last, busy, done}, 64'd0);

    for (int v = 0; v < 5; v++) begin
      build_model(vecs[v].key, vecs[v].dig, vecs[v].mode);
      run_seq(vecs[v].key, vecs[v].dig, vecs[v].mode, vecs[v].stall_at,
              vecs[v].stall_len, 1'b0, vecs[v].mid_start);
      check_stream();
      chk("tab_cycles", 64'(run_cycles), 64'(vecs[v].cycles));
      if (obs_w.size() == 32) begin
        chk("tab_w0", {32'h0, obs_w[0]}, {32'h0, vecs[v].w0});
        chk("tab_m0", {32'h0, obs_w[16]}, {32'h0, vecs[v].m0});
        chk("tab_m4", {32'h0, obs_w[20]}, {32'h0, vecs[v].m4});
        chk("tab_m5", {32'h0, obs_w[21]}, {32'h0, vecs[v].m5});
        chk("tab_m15", {32'h0, obs_w[31]}, {32'h0, vecs[v].m15});
      end
    end

    for (int r = 0; r < 6; r++) begin
      rk = rand_key(); rd = rand_dig(); rm = 1'($urandom);
      build_model(rk, rd, rm);
      run_seq(rk, rd, rm, -1, 0, 1'b1, 1'b0);
      check_stream();
    end

    // Reset in the middle of block 1, then a fresh pass with the same inputs.
    rk = rand_key(); rd = rand_dig(); rm = 1'b1;
    build_model(rk, rd, rm);
    key = rk; digest_in = rd; mode = rm; start = 1'b1; word_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (19) @(negedge clk);
    chk("pre_rst_msg3", {32'h0, word_out}, {32'h0, exp_w[19]});
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("mid_rst_word", {32'h0, word_out}, 64'd0);
    chk("mid_rst_flags", {58'h0, word_valid, blk_first, blk_last, seq_last, busy, done}, 64'd0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("post_rst_quiet", {62'h0, word_valid, done}, 64'd0);
    end
    run_seq(rk, rd, rm, -1, 0, 1'b0, 1'b0);
    check_stream();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
